// File: rtl/ascon_pack.sv
// Shared ASCON definitions: the 5-word permutation state and the round-constant table.
package ascon_pack;

    typedef logic [63:0] type_state [0:4];

    localparam int NUM_ROUNDS = 12;

    localparam logic [7:0] ROUND_CONST [0:NUM_ROUNDS-1] = '{
        8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
    };

    // Out-of-range rounds yield zero so the state passes through untouched.
    function automatic logic [7:0] round_const(input logic [3:0] round);
        logic [7:0] c;
        case (round)
            4'd0:    c = ROUND_CONST[0];
            4'd1:    c = ROUND_CONST[1];
            4'd2:    c = ROUND_CONST[2];
            4'd3:    c = ROUND_CONST[3];
            4'd4:    c = ROUND_CONST[4];
            4'd5:    c = ROUND_CONST[5];
            4'd6:    c = ROUND_CONST[6];
            4'd7:    c = ROUND_CONST[7];
            4'd8:    c = ROUND_CONST[8];
            4'd9:    c = ROUND_CONST[9];
            4'd10:   c = ROUND_CONST[10];
            4'd11:   c = ROUND_CONST[11];
            default: c = 8'h00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/constant_add.sv
// ASCON constant-addition layer: XORs the round constant into word x2, one-cycle registered.
module constant_add
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       en_i,
    input  logic [3:0] round_i,
    input  type_state  S_i,
    output type_state  S_o,
    output logic       valid_o
);

    type_state state_next;
    logic      valid_next;

    always_comb begin
        state_next = S_o;
        valid_next = 1'b0;
        if (en_i) begin
            state_next    = S_i;
            state_next[2] = S_i[2] ^ {56'd0, round_const(round_i)};
            valid_next    = 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            S_o     <= '{default: '0};
            valid_o <= 1'b0;
        end else begin
            S_o     <= state_next;
            valid_o <= valid_next;
        end
    end

endmodule

// File: tb/tb_constant_add.sv
// Self-checking bench for constant_add: directed spec vectors plus randomized traffic vs a reference model.
module tb_constant_add;
    import ascon_pack::*;

    logic       clock_i;
    logic       resetb_i;
    logic       en_i;
    logic [3:0] round_i;
    type_state  S_i;
    type_state  S_o;
    logic       valid_o;

    int vectors;
    int miscompares;

    type_state exp_s;
    logic      exp_v;
    type_state base;

    constant_add dut (
        .clock_i  (clock_i),
        .resetb_i (resetb_i),
        .en_i     (en_i),
        .round_i  (round_i),
        .S_i      (S_i),
        .S_o      (S_o),
        .valid_o  (valid_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    // Reference constant: high nibble counts down from F, low nibble counts up from 0.
    function automatic logic [7:0] ref_const(input logic [3:0] r);
        if (r >= 4'd12) return 8'h00;
        return {4'hF - r, r};
    endfunction

    function automatic logic [319:0] flat(input type_state s);
        return {s[0], s[1], s[2], s[3], s[4]};
    endfunction

    task automatic check_all(input string tag);
        vectors++;
        assert (flat(S_o) === flat(exp_s)) else begin
            miscompares++;
            $error("FAIL %s S_o obs=%h exp=%h", tag, flat(S_o), flat(exp_s));
        end
        vectors++;
        assert (valid_o === exp_v) else begin
            miscompares++;
            $error("FAIL %s valid_o obs=%b exp=%b", tag, valid_o, exp_v);
        end
    endtask

    task automatic check_word2(input string tag, input logic [63:0] want);
        vectors++;
        assert (S_o[2] === want) else begin
            miscompares++;
            $error("FAIL %s S_o[2] obs=%h exp=%h", tag, S_o[2], want);
        end
    endtask

    // One clock: apply inputs, advance the model, sample 1 time unit after the edge.
    task automatic cycle(input logic en, input logic [3:0] r, input type_state s, input string tag);
        en_i    = en;
        round_i = r;
        S_i     = s;
        @(posedge clock_i);
        if (resetb_i) begin
            if (en) begin
                exp_s    = s;
                exp_s[2] = s[2] ^ {56'd0, ref_const(r)};
                exp_v    = 1'b1;
            end else begin
                exp_v = 1'b0;
            end
        end
        #1;
        check_all(tag);
    endtask

    function automatic type_state rand_state();
        type_state s;
        for (int i = 0; i < 5; i++) s[i] = {$urandom, $urandom};
        return s;
    endfunction

    initial begin
        vectors     = 0;
        miscompares = 0;
        base = '{64'h00001000808C0001, 64'h6CB10AD9CA912F80, 64'h691AED630E81901F,
                 64'h0C4C36A20853217C, 64'h46487B3E06D9D7A8};

        // Reset holds outputs at zero even with enable active.
        resetb_i = 1'b0;
        en_i     = 1'b1;
        round_i  = 4'd0;
        S_i      = base;
        exp_s    = '{default: '0};
        exp_v    = 1'b0;
        #2;
        check_all("reset_initial");
        cycle(1'b1, 4'd3, base, "reset_clocked");
        resetb_i = 1'b1;

        // Directed base vectors.
        cycle(1'b1, 4'd0, base, "base_r0");
        check_word2("base_r0_x2", 64'h691AED630E8190EF);
        cycle(1'b1, 4'd11, base, "base_r11");
        check_word2("base_r11_x2", 64'h691AED630E819054);
        cycle(1'b1, 4'd4, base, "base_r4");
        check_word2("base_r4_x2", 64'h691AED630E8190AB);
        cycle(1'b1, 4'd12, base, "pass_r12");
        cycle(1'b1, 4'd15, base, "pass_r15");
        vectors++;
        assert (flat(S_o) === flat(base)) else begin
            miscompares++;
            $error("FAIL pass_r15_ident S_o obs=%h exp=%h", flat(S_o), flat(base));
        end

        // Back-to-back sweep through every valid round.
        for (int r = 0; r < 12; r++) begin
            cycle(1'b1, 4'(r), base, "sweep");
            vectors++;
            assert (S_o[2][7:0] === (8'h1F ^ ref_const(4'(r)))) else begin
                miscompares++;
                $error("FAIL sweep_lsb r=%0d obs=%h exp=%h", r, S_o[2][7:0], 8'h1F ^ ref_const(4'(r)));
            end
        end

        // Hold: enable low for three cycles with changing inputs.
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'($urandom_range(0, 15)), rand_state(), "hold");

        // Randomized traffic.
        for (int i = 0; i < 60; i++)
            cycle(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), rand_state(), "random");

        // Asynchronous reset between edges discards the result immediately.
        cycle(1'b1, 4'd7, rand_state(), "pre_reset");
        #2;
        resetb_i = 1'b0;
        exp_s    = '{default: '0};
        exp_v    = 1'b0;
        #1;
        check_all("async_reset");
        cycle(1'b1, 4'd5, rand_state(), "reset_held");
        #2;
        resetb_i = 1'b1;
        cycle(1'b0, 4'd2, rand_state(), "post_reset_idle");
        cycle(1'b1, 4'd2, rand_state(), "post_reset_capture");
        for (int i = 0; i < 20; i++)
            cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rand_state(), "random2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/constant_add.md
CONSTANT_ADD -- requirements
Module: constant_add

Interface
REQ-001 The module SHALL have no parameters; the state type and the round-constant table SHALL come from the shared package ascon_pack.
REQ-002 clock_i  input  1  single clock for the block; all state updates occur on its rising edge.
REQ-003 resetb_i  input  1  asynchronous, active-low reset.
REQ-004 en_i  input  1  when high, captures S_i and round_i on the next rising edge.
REQ-005 round_i  input  4  round index; 0..11 are valid ASCON rounds, 12..15 are out of range.
REQ-006 S_i  input  type_state (5 x 64 bits)  input state words x0..x4.
REQ-007 S_o  output  type_state (5 x 64 bits)  registered state after constant addition.
REQ-008 valid_o  output  1  high for one cycle when S_o holds a newly computed result.

Function
REQ-009 The round constant c(r) SHALL be taken from this table, for r = 0 to 11 in order: 0xF0, 0xE1, 0xD2, 0xC3, 0xB4, 0xA5, 0x96, 0x87, 0x78, 0x69, 0x5A, 0x4B.
REQ-010 For round_i >= 12, the constant SHALL be 0x00, so the state passes through unchanged.
REQ-011 The 64-bit value zero-extended from c(round_i) SHALL be XORed into word x2 only; only bits [7:0] of x2 can change.
REQ-012 Words x0, x1, x3 and x4 SHALL be copied unmodified.
REQ-013 Latency SHALL be exactly one clock: with en_i high at rising edge N, S_o SHALL equal f(S_i, round_i) sampled at edge N, and valid_o SHALL be 1 after edge N.
REQ-014 With en_i low at a rising edge, S_o SHALL hold its previous value and valid_o SHALL be 0 after that edge.
REQ-015 Back-to-back enables SHALL produce one result per cycle, with valid_o held high continuously.
REQ-016 The combinational path from S_i/round_i to the register input SHALL contain no latches; every round_i value SHALL decode (default branch = 0x00).

Reset
REQ-017 While resetb_i = 0, S_o SHALL be all-zero (320 bits) and valid_o SHALL be 0, independent of clock_i.
REQ-018 A reset asserted mid-operation SHALL discard the pending result; the first capture after deassertion is the next rising edge with en_i = 1.
REQ-019 Reset deassertion SHALL be used synchronously to clock_i by the integrating system; the block adds no synchronizer.

Structure
REQ-020 Package ascon_pack SHALL hold:
- type_state (array [0:4] of 64-bit logic)
- the 12-entry round-constant table as a constant array of 8-bit values
REQ-021 No sub-module is needed; the constant lookup SHALL be implemented as a package function or an indexed constant.
REQ-022 A single always_ff SHALL hold S_o and valid_o; a single always_comb SHALL compute the next state.

Verification
REQ-023 Base vector, round 0: S_i = {0x00001000808C0001, 0x6CB10AD9CA912F80, 0x691AED630E81901F, 0x0C4C36A20853217C, 0x46487B3E06D9D7A8}, round_i = 0, en_i = 1 -> one edge later S_o[2] = 0x691AED630E8190EF, other words identical, valid_o = 1.
REQ-024 Same S_i, round_i = 11 -> S_o[2] = 0x691AED630E819054; round_i = 4 -> S_o[2] = 0x691AED630E8190AB.
REQ-025 Same S_i, round_i = 12 and round_i = 15 -> S_o equals S_i exactly.
REQ-026 Sweep round_i 0..11 on consecutive cycles with en_i held high -> valid_o high throughout and S_o[2][7:0] = 0x1F XOR c(r) each cycle.
REQ-027 Capture a result, then drop en_i for 3 cycles -> S_o stable and valid_o = 0; assert resetb_i = 0 between clock edges -> S_o = 0 and valid_o = 0 immediately.
